// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: fixed-latency word memory answering the LC-3b mem_* handshake.
// Rev 1.0
`default_nettype none

module lc3b_mem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int DELAY     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   output logic        mem_resp
);

   localparam int         DEPTH    = 2**ADDR_BITS;
   localparam logic [3:0] C_DLY_M1 = 4'(DELAY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   wr_q, wr_d;
   logic [ADDR_BITS-1:0]   idx_q, idx_d;
   logic [15:0]            wdata_q, wdata_d;
   logic [1:0]             be_q, be_d;
   logic [15:0]            rdata_q, rdata_d;
   logic [15:0]            mem_q [DEPTH];

   logic                   w_accept;
   logic                   w_complete;
   logic                   w_op_wr;
   logic [ADDR_BITS-1:0]   w_op_idx;
   logic [15:0]            w_op_wdata;
   logic [1:0]             w_op_be;
   logic [15:0]            w_old;
   logic [15:0]            w_merged;
   logic                   w_unused_addr;

   assign w_unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};
   assign w_accept      = (state_q == S_IDLE) && (mem_read || mem_write);

   // With DELAY=1 the access completes on the acceptance edge, so the
   // operation must come straight from the inputs rather than the latches.
   assign w_op_wr    = (state_q == S_IDLE) ? mem_write                     : wr_q;
   assign w_op_idx   = (state_q == S_IDLE) ? mem_address[ADDR_BITS:1]      : idx_q;
   assign w_op_wdata = (state_q == S_IDLE) ? mem_wdata                     : wdata_q;
   assign w_op_be    = (state_q == S_IDLE) ? mem_byte_enable               : be_q;

   assign w_complete = (state_d == S_RESP) && (state_q != S_RESP);
   assign w_old      = mem_q[w_op_idx];
   assign w_merged   = {w_op_be[1] ? w_op_wdata[15:8] : w_old[15:8],
                        w_op_be[0] ? w_op_wdata[7:0]  : w_old[7:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               wr_d    = mem_write;
               idx_d   = mem_address[ADDR_BITS:1];
               wdata_d = mem_wdata;
               be_d    = mem_byte_enable;
               cnt_d   = C_DLY_M1;
               state_d = (DELAY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (w_complete) begin
         rdata_d = w_op_wr ? w_merged : w_old;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 16'h0000;
         be_q    <= 2'b00;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 16'h0000;
         end
      end else if (w_complete && w_op_wr) begin
         mem_q[w_op_idx] <= w_merged;
      end
   end

   assign mem_resp  = (state_q == S_RESP);
   assign mem_rdata = rdata_q;

endmodule

`default_nettype wire
